// File: rtl/display_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
package display_pkg;

  typedef enum logic {S_GUARD, S_ON} scan_state_t;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = 4'b1111;

endpackage

// File: rtl/lz_blank_mask.sv
// Leading-zero blank mask: a digit is blanked while every digit from the left edge down to it
// is zero with no decimal point requested. Digit 0 always stays lit.
module lz_blank_mask
  import display_pkg::*;
(
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_en,
  input  logic                    lz_blank,
  output logic [NUM_DIGITS-1:0]   blank
);

  logic run;

  always_comb begin
    run   = lz_blank;
    blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run      = run && (digits[4*i +: 4] == 4'h0) && !dp_en[i];
      blank[i] = run;
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed 4-digit scan controller: guard/on slots per digit, frame-boundary commit of
// the display word, and registered anode/nibble/decimal-point outputs for the segment decoder.
module display_scanner
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100_000,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_en,
  input  logic        lz_blank,
  output logic [3:0]  digit_data,
  output logic        dp_out,
  output logic [3:0]  AN,
  output logic        frame_done
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] ON_LAST    = CW'(REFRESH_DIV - GUARD_CYCLES - 1);

  scan_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   active_q, active_d, pend_q, pend_d;
  logic [3:0]    act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic          pend_valid_q, pend_valid_d;
  logic          wrap;
  logic [3:0]    blank;
  logic [3:0]    an_q, an_d, data_q, data_d;
  logic          dp_q, dp_d, fd_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    idx_d        = idx_q;
    wrap         = 1'b0;
    active_d     = active_q;
    act_dp_d     = act_dp_q;
    pend_d       = pend_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;

    case (state_q)
      S_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = S_ON;
          cnt_d   = '0;
        end
      end
      S_ON: begin
        if (cnt_q == ON_LAST) begin
          state_d = S_GUARD;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
          wrap    = (idx_q == 2'd3);
        end
      end
      default: begin
        state_d = S_GUARD;
        cnt_d   = '0;
      end
    endcase

    // Commit sees the pending value from before this edge; a coinciding load waits a frame.
    if (wrap && pend_valid_q) begin
      active_d = pend_q;
      act_dp_d = pend_dp_q;
    end
    if (wrap) pend_valid_d = 1'b0;
    if (load) begin
      pend_d       = digits_in;
      pend_dp_d    = dp_en;
      pend_valid_d = 1'b1;
    end
  end

  lz_blank_mask u_lz_blank_mask (
    .digits   (active_d),
    .dp_en    (act_dp_d),
    .lz_blank (lz_blank),
    .blank    (blank)
  );

  // Outputs are computed from next-state values so the registers line up with the slot.
  always_comb begin
    data_d = active_d[{idx_d, 2'b00} +: 4];
    dp_d   = act_dp_d[idx_d] & ~blank[idx_d];
    an_d   = AN_ALL_OFF;
    if (state_d == S_ON && !blank[idx_d]) an_d = ~(4'b0001 << idx_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_GUARD;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      active_q     <= '0;
      act_dp_q     <= '0;
      pend_q       <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      an_q         <= AN_ALL_OFF;
      data_q       <= '0;
      dp_q         <= 1'b0;
      fd_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      act_dp_q     <= act_dp_d;
      pend_q       <= pend_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      an_q         <= an_d;
      data_q       <= data_d;
      dp_q         <= dp_d;
      fd_q         <= wrap;
    end
  end

  assign AN         = an_q;
  assign digit_data = data_q;
  assign dp_out     = dp_q;
  assign frame_done = fd_q;

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexed 4-digit scan controller for the Basys3 seven-segment display: holds a 16-bit BCD/hex display word, cycles one digit at a time, and drives the common anodes plus the 4-bit nibble and decimal-point request consumed directly by `seven_segment_decoder`. It sits between the ADC result formatting logic and the decoder. Features:
- Tear-free updates, committed only at frame boundaries.
- Anti-ghosting guard interval between digits.
- Optional leading-zero blanking.

## Interface
Parameters:
- REFRESH_DIV, default 100_000: clock cycles per digit slot (1 kHz per digit at 100 MHz); must be ≥ 2.
- GUARD_CYCLES, default 16: all-anodes-off cycles at the start of each slot; 1 ≤ GUARD_CYCLES < REFRESH_DIV.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- load  in  1  single-cycle strobe; captures digits_in and dp_en into the pending register.
- digits_in  in  16  four nibbles; [3:0] is the rightmost digit (AN[0]), [15:12] is the leftmost (AN[3]).
- dp_en  in  4  per-digit decimal-point enable, same indexing as the anodes.
- lz_blank  in  1  1 = suppress leading zeros.
- digit_data  out  4  nibble routed to decoder `data`.
- dp_out  out  1  routed to decoder `dp_in`; 1 = DP lit.
- AN  out  4  anode enables, active-low.
- frame_done  out  1  one-cycle pulse when the digit-3 slot ends.

## Operation
- FSM states are S_GUARD and S_ON. Each slot is GUARD_CYCLES cycles of S_GUARD followed by REFRESH_DIV−GUARD_CYCLES cycles of S_ON.
- S_ON → S_GUARD increments the digit index mod 4.
- Slot counter width is $clog2(REFRESH_DIV). It resets to 0 on every state change.
- S_GUARD behaviour:
  - AN = 4'b1111.
  - digit_data and dp_out already present the current index's values, so the decoder settles before the anode turns on.
- S_ON behaviour:
  - AN has the current index's bit low, unless that digit is blanked.
  - A blanked digit keeps AN = 4'b1111, with dp_out = 0.
- Leading-zero blanking: digit i (i = 3..1) is blanked when all of the following hold:
  - lz_blank = 1;
  - every active nibble from 3 down to i is 0;
  - no dp_en bit from 3 down to i is set.
- Digit 0 is never blanked.
- Blanking uses the active (committed) register and the live lz_blank.
- Load and commit:
  - load writes the pending register and sets pending_valid. Multiple loads before a commit: the last one wins.
  - Commit happens on the S_ON → S_GUARD edge that wraps the index 3 → 0. At that edge, active ← pending and pending_valid clears. The same edge pulses frame_done.
  - If load and commit coincide, the commit uses the pending value from before that edge. The new load commits at the next wrap.
- Reset values:
  - AN = 4'b1111, digit_data = 0, dp_out = 0, frame_done = 0.
  - Active, pending and pending_valid are all 0.
  - Index = 0, state = S_GUARD, counter = 0.
- Reset asserted mid-slot returns everything to reset values on the next edge. No partial slot is completed.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- After reset deasserts, AN stays 4'b1111 for GUARD_CYCLES cycles. AN[0] then goes low for REFRESH_DIV−GUARD_CYCLES cycles.
- Digit period is REFRESH_DIV cycles; frame period is 4·REFRESH_DIV cycles.
- frame_done is high for exactly one cycle per frame, coincident with the first S_GUARD cycle of digit 0.
- Load-to-display latency: until the next wrap, at most 4·REFRESH_DIV cycles. The new value appears on digit_data in the first cycle after the wrap.
- At most one AN bit is low in any cycle.

## Structure
- Shared package `display_pkg` contains:
  - `scan_state_t` enum {S_GUARD, S_ON};
  - `NUM_DIGITS = 4`;
  - `AN_ALL_OFF = 4'b1111`.
- Sub-module `lz_blank_mask`: combinational. Inputs are the active word, dp_en and lz_blank; output is a 4-bit blank mask. The FSM, counter, registers and output muxing stay in display_scanner.

## Test plan
Bench parameters: REFRESH_DIV = 8, GUARD_CYCLES = 2.
- Reset release, no load -> AN = 1111 for 2 cycles, then 1110 for 6 cycles with digit_data = 0, then 1111, then 1101. frame_done first pulses at cycle 32.
- load with digits_in = 16'h1234, dp_en = 0100 -> from the next wrap, digit_data sequence 4, 3, 2, 1 with AN 1110, 1101, 1011, 0111. dp_out = 1 only during the digit-2 slot.
- lz_blank = 1, committed 16'h0050, dp_en = 0 -> digits 3 and 2 keep AN = 1111. Digits 1 and 0 light, showing 5 and 0.
- lz_blank = 1, 16'h0005, dp_en = 0010 -> digit 1 lit showing 0 with dp_out = 1. Digit 0 shows 5.
- load 16'hAAAA on the wrap edge, then load 16'hBBBB mid-frame -> the frame after that wrap shows the prior pending value. The following frame shows 16'hBBBB; 16'hAAAA never appears.
- Reset pulsed during the AN = 1011 slot -> next cycle AN = 1111, digit_data = 0, and the sequence restarts from digit 0 with the active word = 0.
